// File: rtl/alu_muldiv_seq.sv
// rtl/alu_muldiv_seq.sv - iterative RV32M multiply/divide sequencer with pipeline stall
// Optional macro MULDIV_EARLY_OUT_EN: finish trivial operands (div by zero, overflow, zero factor) from PREP.
module alu_muldiv_seq #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            Start,
   input  logic            Flush,
   input  logic [2:0]      Funct3,
   input  logic [XLEN-1:0] SrcA,
   input  logic [XLEN-1:0] SrcB,
   output logic            Busy,
   output logic            Stall,
   output logic            Done,
   output logic [XLEN-1:0] Result
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_PREP = 3'd1;
   localparam logic [2:0] S_CALC = 3'd2;
   localparam logic [2:0] S_FIX  = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   logic [2:0]        state;
   logic [2:0]        op;
   logic [XLEN-1:0]   opa;
   logic [XLEN-1:0]   opb;
   logic [XLEN-1:0]   spec_val;
   logic [5:0]        cnt;
   logic [2*XLEN-1:0] acc;
   logic              neg;
   logic              special;

   logic              is_div, is_rem, signed_a, signed_b, sa, sb;
   logic [XLEN-1:0]   abs_a, abs_b;
   logic              div_zero, div_ovf, neg_prep;
   logic [XLEN-1:0]   spec_val_prep;
   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] mul_next, div_next, prod;
   logic              div_ok;
   logic [XLEN-1:0]   div_rem, quot, remv, fix_val;
`ifdef MULDIV_EARLY_OUT_EN
   logic              mul_zero;
`endif

   always_comb begin
      is_div   = op[2];
      is_rem   = op[2] & op[1];
      signed_a = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
      signed_b = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
      sa       = signed_a & opa[XLEN-1];
      sb       = signed_b & opb[XLEN-1];
      abs_a    = sa ? -opa : opa;
      abs_b    = sb ? -opb : opb;
      neg_prep = is_rem ? sa : (sa ^ sb);
      div_zero = is_div && (opb == '0);
      div_ovf  = !op[0] && is_div && (opa == MIN_NEG) && (opb == '1);
      spec_val_prep = div_zero ? (is_rem ? opa : '1) : (is_rem ? '0 : MIN_NEG);
`ifdef MULDIV_EARLY_OUT_EN
      mul_zero = !is_div && ((opa == '0) || (opb == '0));
`endif

      // Shift-add: the carry out of the upper-half add becomes the new MSB.
      mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
      mul_next = {mul_sum, acc[XLEN-1:1]};

      // Restoring divide: compare on XLEN+1 bits so divisors above 2^(XLEN-1) work.
      div_ok   = acc[2*XLEN-1:XLEN-1] >= {1'b0, opb};
      div_rem  = acc[2*XLEN-2:XLEN-1] - opb;
      div_next = div_ok ? {div_rem, acc[XLEN-2:0], 1'b1} : {acc[2*XLEN-2:0], 1'b0};

      prod = neg ? -acc : acc;
      quot = neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      remv = neg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
      if (special)           fix_val = spec_val;
      else if (!is_div)      fix_val = (op == 3'b000) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
      else if (is_rem)       fix_val = remv;
      else                   fix_val = quot;
   end

   assign Busy  = (state != S_IDLE);
   assign Stall = (Start && (state == S_IDLE)) || (state == S_PREP) ||
                  (state == S_CALC) || (state == S_FIX);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         op       <= '0;
         opa      <= '0;
         opb      <= '0;
         spec_val <= '0;
         cnt      <= '0;
         acc      <= '0;
         neg      <= 1'b0;
         special  <= 1'b0;
         Done     <= 1'b0;
         Result   <= '0;
      end else begin
         Done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (Start && !Flush) begin
                  op    <= Funct3;
                  opa   <= SrcA;
                  opb   <= SrcB;
                  state <= S_PREP;
               end
            end
            S_PREP: begin
               if (Flush) begin
                  state <= S_IDLE;
               end else begin
                  neg      <= neg_prep;
                  special  <= div_zero | div_ovf;
                  spec_val <= spec_val_prep;
                  opb      <= abs_b;
                  acc      <= {{XLEN{1'b0}}, abs_a};
                  cnt      <= 6'(XLEN-1);
                  state    <= S_CALC;
`ifdef MULDIV_EARLY_OUT_EN
                  if (div_zero || div_ovf || mul_zero) begin
                     Result <= mul_zero ? '0 : spec_val_prep;
                     Done   <= 1'b1;
                     state  <= S_DONE;
                  end
`endif
               end
            end
            S_CALC: begin
               if (Flush) begin
                  state <= S_IDLE;
               end else begin
                  acc <= is_div ? div_next : mul_next;
                  cnt <= cnt - 6'd1;
                  if (cnt == 6'd0) state <= S_FIX;
               end
            end
            S_FIX: begin
               if (Flush) begin
                  state <= S_IDLE;
               end else begin
                  Result <= fix_val;
                  Done   <= 1'b1;
                  state  <= S_DONE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb/tb_alu_muldiv_seq.sv - directed scoreboard bench for alu_muldiv_seq
module tb_alu_muldiv_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        Start, Flush;
   logic [2:0]  Funct3;
   logic [31:0] SrcA, SrcB;
   logic        Busy, Stall, Done;
   logic [31:0] Result;

   int n_pass = 0;
   int n_fail = 0;
   int n_chk  = 0;
   logic [31:0] sb_q[$];
   logic [31:0] last_res;

   alu_muldiv_seq #(.XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n), .Start(Start), .Flush(Flush), .Funct3(Funct3),
      .SrcA(SrcA), .SrcB(SrcB), .Busy(Busy), .Stall(Stall), .Done(Done), .Result(Result)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_fn(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] xa, xb, ua, ub, p;
      logic [31:0] r;
      logic ovf;
      xa  = {{32{a[31]}}, a};
      xb  = {{32{b[31]}}, b};
      ua  = {32'b0, a};
      ub  = {32'b0, b};
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (f)
         3'd0: begin p = ua * ub; r = p[31:0]; end
         3'd1: begin p = xa * xb; r = p[63:32]; end
         3'd2: begin p = xa * ub; r = p[63:32]; end
         3'd3: begin p = ua * ub; r = p[63:32]; end
         3'd4: r = (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : $signed(a) / $signed(b);
         3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: r = (b == 0) ? a : ovf ? 32'h0 : $signed(a) % $signed(b);
         default: r = (b == 0) ? a : a % b;
      endcase
      return r;
   endfunction

   function automatic int lat_of(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
      if (f[2] && b == 0) return 2;
      if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
      if (!f[2] && (a == 0 || b == 0)) return 2;
`endif
      return 35;
   endfunction

   // Called at a negedge with the DUT idle; returns at the negedge after DONE.
   task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] expv);
      int  c;
      int  lat;
      bit  stall_ok;
      bit  seen;
      logic [31:0] e;
      lat = lat_of(f, a, b);
      Start = 1'b1; Funct3 = f; SrcA = a; SrcB = b;
      #1 check({tag, "_stall_c0"}, 32'(Stall), 32'd1);
      sb_q.push_back(expv);
      @(negedge clk);
      Start = 1'b0; SrcA = $urandom; SrcB = $urandom; Funct3 = 3'($urandom_range(0, 7));
      stall_ok = 1'b1; seen = 1'b0;
      for (c = 1; c <= 60; c++) begin
         #1;
         if (Done) begin seen = 1'b1; break; end
         if (!Stall || !Busy) stall_ok = 1'b0;
         Start = (c == 5);
         @(negedge clk);
      end
      Start = 1'b0;
      check({tag, "_stall_run"}, 32'(stall_ok), 32'd1);
      if (seen) begin
         check({tag, "_latency"}, 32'(c), 32'(lat));
         check({tag, "_stall_done"}, 32'(Stall), 32'd0);
         e = sb_q.pop_front();
         check({tag, "_result"}, Result, e);
         last_res = e;
      end else begin
         check({tag, "_done_timeout"}, 32'd0, 32'd1);
         void'(sb_q.pop_front());
      end
      @(negedge clk);
      #1 check({tag, "_idle_after"}, {30'd0, Busy, Done}, 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; Start = 1'b0; Flush = 1'b0; Funct3 = '0; SrcA = '0; SrcB = '0;
      last_res = '0;
      repeat (3) @(negedge clk);
      #1 check("reset_outputs", {Busy, Stall, Done, Result[28:0]}, 32'd0);
      check("reset_result", Result, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      run_op("mul_7x6",    3'd0, 32'd7,         32'd6,         32'd42);
      run_op("mulh_m1m1",  3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
      run_op("mulhu_m1m1", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      run_op("mulhsu",     3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF);
      run_op("div_m7_2",   3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
      run_op("rem_m7_2",   3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
      run_op("divu_5_0",   3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF);
      run_op("remu_5_0",   3'd7, 32'd5,         32'd0,         32'd5);
      run_op("div_ovf",    3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
      run_op("rem_ovf",    3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
      run_op("rem_m9_0",   3'd6, 32'hFFFF_FFF7, 32'd0,         32'hFFFF_FFF7);
      run_op("divu_big",   3'd5, 32'hFFFF_FFFE, 32'h8000_0001, 32'd1);
      run_op("remu_big",   3'd7, 32'hFFFF_FFFE, 32'h8000_0001, 32'h7FFF_FFFD);
      run_op("mul_zero",   3'd0, 32'd0,         32'h1234_5678, 32'd0);
      for (int i = 0; i < 4; i++) begin
         logic [2:0]  f;
         logic [31:0] a, b;
         f = 3'(i * 2 + 1);
         a = $urandom;
         b = $urandom | 32'h1;
         run_op("random", f, a, b, ref_fn(f, a, b));
      end

      // Start with Flush in IDLE is refused
      Start = 1'b1; Flush = 1'b1; Funct3 = 3'd0; SrcA = 32'd2; SrcB = 32'd2;
      @(negedge clk);
      Start = 1'b0; Flush = 1'b0;
      #1 check("start_flush_idle", 32'(Busy), 32'd0);
      @(negedge clk);

      // Flush mid-calculation
      begin
         bit saw_done;
         saw_done = 1'b0;
         Start = 1'b1; Funct3 = 3'd0; SrcA = 32'd3; SrcB = 32'd3;
         @(negedge clk);
         Start = 1'b0;
         for (int c = 1; c < 10; c++) begin
            #1 if (Done) saw_done = 1'b1;
            @(negedge clk);
         end
         Flush = 1'b1;
         #1 if (Done) saw_done = 1'b1;
         @(negedge clk);
         Flush = 1'b0;
         #1 if (Done) saw_done = 1'b1;
         check("flush_idle", 32'(Busy), 32'd0);
         check("flush_no_done", 32'(saw_done), 32'd0);
         check("flush_result_held", Result, last_res);
         @(negedge clk);
         run_op("after_flush", 3'd0, 32'd3, 32'd3, 32'd9);
      end

      // Reset mid-operation
      Start = 1'b1; Funct3 = 3'd5; SrcA = 32'd100; SrcB = 32'd7;
      @(negedge clk);
      Start = 1'b0;
      repeat (19) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      #1 check("midreset_flags", {29'd0, Busy, Stall, Done}, 32'd0);
      check("midreset_result", Result, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      run_op("divu_100_7", 3'd5, 32'd100, 32'd7, 32'd14);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
